// File: rtl/qspi_flash_rom_model.sv
// Read-only quad-SPI NOR flash model: Quad I/O Fast Read (0xEB) with continuous (XIP) mode.
// First data nibble is registered on the edge that ends the last dummy clock; the host cannot stall the flash.
module qspi_flash_rom_model #(
  parameter int MEM_BYTES  = 65536,
  parameter int DUMMY_CLKS = 4
) (
  input  logic       spi_clk,
  input  logic       rst,
  input  logic       spi_cs_n,
  input  logic [3:0] spi_data_in,
  input  logic [3:0] spi_data_oe,
  output logic [3:0] spi_data_out
);

  localparam int AW = $clog2(MEM_BYTES);

  localparam logic [2:0] ST_CMD    = 3'd0;
  localparam logic [2:0] ST_ADDR   = 3'd1;
  localparam logic [2:0] ST_MODE   = 3'd2;
  localparam logic [2:0] ST_DUMMY  = 3'd3;
  localparam logic [2:0] ST_DATA   = 3'd4;
  localparam logic [2:0] ST_IGNORE = 3'd5;

  // Flash image; erased cells read as 8'hFF. Never written by the bus.
  logic [7:0] mem [MEM_BYTES] = '{default: 8'hFF};

  logic [2:0]    state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [6:0]    cmd_q, cmd_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [3:0]    mode_hi_q, mode_hi_d;
  logic          lo_q, lo_d;
  logic [3:0]    dout_q, dout_d;
  logic          cont_q, cont_d;
  logic [7:0]    rd_byte;

  assign rd_byte      = mem[addr_q];
  assign spi_data_out = dout_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    mode_hi_d = mode_hi_q;
    lo_d      = lo_q;
    dout_d    = 4'h0;
    cont_d    = cont_q;
    case (state_q)
      ST_CMD: begin
        cmd_d = {cmd_q[5:0], spi_data_in[0]};
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'd7) begin
          cnt_d   = 8'd0;
          state_d = ({cmd_q, spi_data_in[0]} == 8'hEB) ? ST_ADDR : ST_IGNORE;
        end
      end
      ST_ADDR: begin
        // Bits above the array size fall off the top, giving modulo-size wrap.
        addr_d = AW'({addr_q, spi_data_in});
        cnt_d  = cnt_q + 8'd1;
        if (cnt_q == 8'd5) begin
          cnt_d   = 8'd0;
          state_d = ST_MODE;
        end
      end
      ST_MODE: begin
        if (cnt_q == 8'd0) begin
          mode_hi_d = spi_data_in;
          cnt_d     = 8'd1;
        end else begin
          cont_d  = (mode_hi_q == 4'hA);
          cnt_d   = 8'd0;
          state_d = ST_DUMMY;
        end
      end
      ST_DUMMY: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'(DUMMY_CLKS - 1)) begin
          cnt_d   = 8'd0;
          state_d = ST_DATA;
          dout_d  = rd_byte[7:4];
          lo_d    = 1'b1;
        end
      end
      ST_DATA: begin
        if (lo_q) begin
          dout_d = rd_byte[3:0];
          addr_d = addr_q + AW'(1);
          lo_d   = 1'b0;
        end else begin
          dout_d = rd_byte[7:4];
          lo_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Deselect ends the transaction immediately; only continuous mode survives it.
  always_ff @(posedge spi_clk or posedge spi_cs_n) begin
    if (spi_cs_n) begin
      state_q <= (cont_q && !rst) ? ST_ADDR : ST_CMD;
      cnt_q   <= 8'd0;
      lo_q    <= 1'b0;
      dout_q  <= 4'h0;
    end else if (rst) begin
      state_q <= ST_CMD;
      cnt_q   <= 8'd0;
      lo_q    <= 1'b0;
      dout_q  <= 4'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lo_q    <= lo_d;
      dout_q  <= dout_d;
    end
  end

  always_ff @(posedge spi_clk) begin
    if (rst) begin
      cont_q <= 1'b0;
    end else if (!spi_cs_n) begin
      cont_q <= cont_d;
    end
  end

  always_ff @(posedge spi_clk) begin
    if (!spi_cs_n) begin
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      mode_hi_q <= mode_hi_d;
    end
  end

  // Host must release the IO lines while the flash is returning data.
  a_no_contention: assert property (@(posedge spi_clk) disable iff (rst)
    !(state_q == ST_DATA && spi_data_oe != 4'h0));

endmodule

// File: tb/tb_qspi_flash_rom_model.sv
// Directed and randomized reads of the quad-SPI flash model against an array-based reference.
module tb_qspi_flash_rom_model;
  localparam int MEM = 65536;
  localparam int DUM = 4;

  logic       spi_clk = 1'b0;
  logic       rst = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic [3:0] din = 4'h0;
  logic [3:0] oe = 4'h0;
  logic [3:0] dout;

  int checks = 0;
  int errors = 0;
  logic [7:0] img [MEM];
  bit cont_m = 1'b0;

  qspi_flash_rom_model #(.MEM_BYTES(MEM), .DUMMY_CLKS(DUM)) dut (
    .spi_clk(spi_clk), .rst(rst), .spi_cs_n(spi_cs_n),
    .spi_data_in(din), .spi_data_oe(oe), .spi_data_out(dout)
  );

  always #5 spi_clk = ~spi_clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic cs, input logic [3:0] d, input logic [3:0] e);
    @(negedge spi_clk);
    spi_cs_n = cs;
    din      = d;
    oe       = e;
  endtask

  task automatic send_cmd(input logic [7:0] c);
    for (int i = 7; i >= 0; i--) tick(1'b0, {3'b000, c[i]}, 4'h1);
  endtask

  task automatic send_addr(input logic [23:0] a);
    for (int i = 5; i >= 0; i--) tick(1'b0, a[i*4 +: 4], 4'hF);
  endtask

  task automatic send_mode(input logic [7:0] m);
    tick(1'b0, m[7:4], 4'hF);
    tick(1'b0, m[3:0], 4'hF);
    cont_m = (m[7:4] == 4'hA);
  endtask

  task automatic send_dummy();
    for (int i = 0; i < DUM; i++) tick(1'b0, 4'($urandom), 4'h0);
  endtask

  // Nibble k of a read starting at byte a: high half first, byte address wraps modulo MEM.
  function automatic logic [3:0] exp_nib(input logic [23:0] a, input int k);
    logic [7:0] b;
    b = img[(int'(a) + k / 2) % MEM];
    return (k % 2 == 0) ? b[7:4] : b[3:0];
  endfunction

  task automatic read_check(input string tag, input logic [23:0] a, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge spi_clk);
      check(tag, dout, exp_nib(a, k));
      din = 4'($urandom);
    end
  endtask

  task automatic txn(input bit use_cmd, input logic [23:0] a, input logic [7:0] m,
                     input int n, input string tag);
    if (use_cmd) send_cmd(8'hEB);
    send_addr(a);
    send_mode(m);
    send_dummy();
    read_check(tag, a, n);
  endtask

  task automatic deselect();
    tick(1'b1, 4'h0, 4'hF);
    tick(1'b1, 4'h0, 4'hF);
  endtask

  initial begin
    logic [23:0] a;
    logic [7:0]  m;

    for (int i = 0; i < MEM; i++) img[i] = (i < MEM / 2) ? 8'($urandom) : 8'hFF;
    img[0] = 8'h13; img[1] = 8'h05; img[2] = 8'h00; img[3] = 8'h00;
    img[MEM-1] = 8'hAB;

    @(negedge spi_clk);
    for (int i = 0; i < MEM / 2; i++) dut.mem[i] = img[i];
    dut.mem[MEM-1] = img[MEM-1];

    rst = 1'b1;
    tick(1'b1, 4'h0, 4'h0);
    tick(1'b0, 4'h0, 4'h0);
    @(negedge spi_clk);
    check("reset_dout", dout, 4'h0);
    rst = 1'b0;
    cont_m = 1'b0;
    deselect();

    txn(1'b1, 24'h000000, 8'hA0, 8, "eb_read_0");
    deselect();

    txn(1'b0, 24'h000002, 8'hA0, 4, "xip_read_2");
    deselect();

    a = 24'($urandom);
    txn(1'b0, a, 8'hFF, 4, "xip_mode_ff");
    deselect();
    a = 24'($urandom);
    txn(1'b1, a, 8'hFF, 6, "eb_after_ff");
    deselect();

    send_cmd(8'h03);
    for (int i = 0; i < 40; i++) begin
      tick(1'b0, 4'($urandom), 4'h0);
      check("ignored_cmd_out", dout, 4'h0);
    end
    deselect();

    txn(1'b1, 24'h00FFFF, 8'h00, 4, "wrap_ffff");
    deselect();

    send_cmd(8'hEB);
    for (int i = 0; i < 3; i++) tick(1'b0, 4'($urandom), 4'hF);
    deselect();
    txn(1'b1, 24'h000001, 8'h00, 2, "after_abort");
    deselect();

    a = 24'($urandom);
    txn(1'b1, a, 8'hA0, 3, "pre_rst");
    rst = 1'b1;
    @(negedge spi_clk);
    check("rst_in_data", dout, 4'h0);
    rst = 1'b0;
    cont_m = 1'b0;
    deselect();
    a = 24'($urandom);
    txn(1'b1, a, 8'h00, 4, "cmd_after_rst");
    deselect();

    for (int t = 0; t < 10; t++) begin
      a = 24'($urandom);
      m = 8'($urandom);
      if ($urandom_range(0, 1) == 1) m[7:4] = 4'hA;
      txn(!cont_m, a, m, $urandom_range(1, 24), "random_read");
      deselect();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
